rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
- Central reset controller for the RISCII processor.
- Takes the raw board reset and a clock-stable indication, synchronizes reset release, and releases the memory, core and peripheral reset domains in a fixed staged order.
- Also services software, watchdog and clock-loss reset events.
- All per-domain reset outputs are built from async-reset/sync-release flops, so they assert immediately and deassert cleanly on clk.

Parameters:
SYNC_STAGES, 2, depth of the rstn release synchronizer and of the clk_ok synchronizer (min 2)
HOLD_CYCLES, 16, cycles all domains stay in reset after entering HOLD (min 1)
STAGE_GAP, 4, cycles between successive domain releases (min 1)
CNT_W, 8, width of the shared hold/gap down-counter; must hold max(HOLD_CYCLES, STAGE_GAP)

Ports:
clk          in   1  system clock
rstn         in   1  reset, asynchronous, active-low (already decided; clock clk)
clk_ok       in   1  PLL/oscillator stable, asynchronous to clk; synchronized internally
sw_rst_req   in   1  software reset request, synchronous one-cycle pulse
wdt_rst_req  in   1  watchdog reset request, synchronous one-cycle pulse
rstn_mem     out  1  memory-domain reset, active-low
rstn_core    out  1  core-domain reset, active-low
rstn_periph  out  1  peripheral-domain reset, active-low
seq_done     out  1  high while in RUN
rst_cause    out  2  last reset cause: 0 POR, 1 SW, 2 WDT, 3 CLK-loss

Behaviour:
- **rstn low (asynchronous):**
  - Both synchronizers cleared.
  - FSM forced to RESET.
  - rstn_mem, rstn_core, rstn_periph, seq_done = 0.
  - rst_cause = 0.
  - Counter = 0.
- **Release synchronizer:** rst_sync rises on the SYNC_STAGES-th clk edge after rstn rises. clk_ok_s is clk_ok delayed through SYNC_STAGES flops.
- **FSM states:** RESET, WAIT_CLK, HOLD, REL_MEM, REL_CORE, RUN.
  - **RESET:**
    - Exit only when rst_sync = 1.
    - If clk_ok_s = 1, go to HOLD and load the counter with HOLD_CYCLES-1.
    - Otherwise go to WAIT_CLK.
  - **WAIT_CLK:** go to HOLD (counter loaded with HOLD_CYCLES-1) on the first edge where clk_ok_s = 1.
  - **HOLD:**
    - Counter decrements each cycle.
    - At counter = 0: set rstn_mem = 1, load the counter with STAGE_GAP-1, go to REL_MEM.
    - Net effect: rstn_mem rises exactly HOLD_CYCLES edges after the HOLD entry edge.
  - **REL_MEM:** at counter = 0, set rstn_core = 1, reload STAGE_GAP-1, go to REL_CORE.
  - **REL_CORE:** at counter = 0, set rstn_periph = 1 and seq_done = 1, go to RUN.
  - **RUN:** holding state; leaves only on a reset event (below).
- **Reset events** (registered, effective on the sampling edge):
  - **Software/watchdog (RUN only):** sw_rst_req or wdt_rst_req high on an edge while in RUN:
    - All three domain resets and seq_done go to 0 on that edge.
    - rst_cause = 2 if wdt_rst_req is high, else 1. Watchdog wins if both are high.
    - FSM enters HOLD with counter = HOLD_CYCLES-1.
    - The sequence then repeats from HOLD.
  - **Requests outside RUN:** ignored; the domains are already sequencing.
  - **Clock loss:** clk_ok_s = 0 in HOLD, REL_MEM, REL_CORE or RUN:
    - All domain resets and seq_done go to 0.
    - rst_cause = 3.
    - FSM goes to WAIT_CLK.
    - Clock loss has priority over sw/wdt requests on the same edge.
  - **clk_ok_s = 0 in WAIT_CLK:** no effect.
- **Output ordering invariants:**
  - The three domain outputs never deassert out of order; rstn_periph=1 implies rstn_core=1, which implies rstn_mem=1.
  - All assertions are simultaneous.
- **rst_cause persistence:** holds its value until the next reset event or until rstn goes low.
- **rstn low mid-sequence:** immediate return to full reset, as above.

Optional Feature:
Macro RST_DEBUG_HOLD_EN.
- **Defined:**
  - Adds input dbg_hold (1 bit, synchronous).
  - While dbg_hold = 1 in REL_MEM with counter = 0, the FSM stays in REL_MEM and rstn_core stays 0.
  - When dbg_hold drops, release proceeds on the next edge: rstn_core rises, counter reloads STAGE_GAP-1.
  - dbg_hold has no effect in any other state.
- **Not defined:** the port does not exist and behaviour is as above with dbg_hold treated as 0.

Test Plan:
Bench defaults are SYNC_STAGES=2, HOLD_CYCLES=16, STAGE_GAP=4.
1. **POR:** rstn low 5 cycles, clk_ok=1 throughout, rstn released before edge 1 -> HOLD entered edge 3; rstn_mem rises edge 19, rstn_core edge 23, rstn_periph and seq_done edge 27; rst_cause=0.
2. **Late clock:** clk_ok=0 at rstn release, raised before edge 10 -> clk_ok_s=1 by edge 11, HOLD entered edge 12; rstn_mem edge 28, rstn_periph edge 36.
3. **Software reset:** in RUN, sw_rst_req pulse sampled edge N -> all outputs 0 after edge N, rst_cause=1; rstn_mem N+16, rstn_core N+20, rstn_periph N+24.
4. **Simultaneous requests:** sw_rst_req and wdt_rst_req on the same edge in RUN -> rst_cause=2; the same timing as case 3. A second sw pulse at N+5 is ignored, and the release times are unchanged.
5. **Clock loss:** in RUN, clk_ok drops -> two edges later all outputs 0, rst_cause=3, WAIT_CLK. Restore clk_ok -> full HOLD+stage sequence.
6. **Reset mid-sequence:** rstn asserted mid-REL_MEM -> rstn_mem drops immediately (no clk edge needed), rst_cause=0. With RST_DEBUG_HOLD_EN defined, dbg_hold=1 keeps rstn_core=0 indefinitely, and rstn_core rises one edge after dbg_hold falls.

Source files
------------

// File: rtl/rst_sequencer.sv
// rst_sequencer: central reset controller for the RISCII processor.
//
// Synchronizes release of the raw board reset, waits for a stable clock,
// holds every domain in reset for HOLD_CYCLES, then releases the memory,
// core and peripheral domains in that order, STAGE_GAP cycles apart.
// Software, watchdog and clock-loss events restart the sequence.
//
// Ports:
//   clk          in   system clock
//   rstn         in   asynchronous active-low board reset
//   clk_ok       in   PLL/oscillator stable (asynchronous, synchronized here)
//   sw_rst_req   in   software reset request, one-cycle pulse
//   wdt_rst_req  in   watchdog reset request, one-cycle pulse
//   dbg_hold     in   (RST_DEBUG_HOLD_EN only) stall before core release
//   rstn_mem     out  memory-domain reset, active-low
//   rstn_core    out  core-domain reset, active-low
//   rstn_periph  out  peripheral-domain reset, active-low
//   seq_done     out  high while in RUN
//   rst_cause    out  last reset cause: 0 POR, 1 SW, 2 WDT, 3 clock loss
//
// Optional feature: define RST_DEBUG_HOLD_EN to add the dbg_hold input.

module rst_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clk_ok,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
`ifdef RST_DEBUG_HOLD_EN
  input  logic       dbg_hold,
`endif
  output logic       rstn_mem,
  output logic       rstn_core,
  output logic       rstn_periph,
  output logic       seq_done,
  output logic [1:0] rst_cause
);

  typedef enum logic [2:0] {
    S_RESET, S_WAIT_CLK, S_HOLD, S_REL_MEM, S_REL_CORE, S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;
  localparam logic [1:0] CAUSE_CLK = 2'd3;

`ifndef RST_DEBUG_HOLD_EN
  logic dbg_hold;
  assign dbg_hold = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] rst_pipe;
  logic [SYNC_STAGES-1:0] clk_ok_pipe;
  logic                   rst_sync;
  logic                   clk_ok_s;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mem_nxt, core_nxt, periph_nxt, done_nxt;
  logic [1:0]       cause_nxt;

  // Synchronizer stage: reset release and clk_ok brought into clk domain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_pipe    <= '0;
      clk_ok_pipe <= '0;
    end else begin
      rst_pipe    <= {rst_pipe[SYNC_STAGES-2:0], 1'b1};
      clk_ok_pipe <= {clk_ok_pipe[SYNC_STAGES-2:0], clk_ok};
    end
  end

  assign rst_sync = rst_pipe[SYNC_STAGES-1];
  assign clk_ok_s = clk_ok_pipe[SYNC_STAGES-1];

  // Sequencer stage: state, counter and registered domain resets
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_RESET;
      cnt         <= '0;
      rstn_mem    <= 1'b0;
      rstn_core   <= 1'b0;
      rstn_periph <= 1'b0;
      seq_done    <= 1'b0;
      rst_cause   <= CAUSE_POR;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rstn_mem    <= mem_nxt;
      rstn_core   <= core_nxt;
      rstn_periph <= periph_nxt;
      seq_done    <= done_nxt;
      rst_cause   <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mem_nxt    = rstn_mem;
    core_nxt   = rstn_core;
    periph_nxt = rstn_periph;
    done_nxt   = seq_done;
    cause_nxt  = rst_cause;

    case (state)
      S_RESET: begin
        if (rst_sync) begin
          if (clk_ok_s) begin
            state_nxt = S_HOLD;
            cnt_nxt   = HOLD_LOAD;
          end else begin
            state_nxt = S_WAIT_CLK;
          end
        end
      end
      S_WAIT_CLK: begin
        if (clk_ok_s) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          mem_nxt   = 1'b1;
          cnt_nxt   = GAP_LOAD;
          state_nxt = S_REL_MEM;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_REL_MEM: begin
        // Counter parks at zero while dbg_hold stalls the core release.
        if (cnt == '0) begin
          if (!dbg_hold) begin
            core_nxt  = 1'b1;
            cnt_nxt   = GAP_LOAD;
            state_nxt = S_REL_CORE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_REL_CORE: begin
        if (cnt == '0) begin
          periph_nxt = 1'b1;
          done_nxt   = 1'b1;
          state_nxt  = S_RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (sw_rst_req || wdt_rst_req) begin
          mem_nxt    = 1'b0;
          core_nxt   = 1'b0;
          periph_nxt = 1'b0;
          done_nxt   = 1'b0;
          cause_nxt  = wdt_rst_req ? CAUSE_WDT : CAUSE_SW;
          state_nxt  = S_HOLD;
          cnt_nxt    = HOLD_LOAD;
        end
      end
      default: begin
        state_nxt = S_RESET;
        cnt_nxt   = '0;
      end
    endcase

    // Clock loss overrides any sw/wdt request seen on the same edge.
    if (!clk_ok_s && (state == S_HOLD || state == S_REL_MEM ||
                      state == S_REL_CORE || state == S_RUN)) begin
      mem_nxt    = 1'b0;
      core_nxt   = 1'b0;
      periph_nxt = 1'b0;
      done_nxt   = 1'b0;
      cause_nxt  = CAUSE_CLK;
      state_nxt  = S_WAIT_CLK;
      cnt_nxt    = '0;
    end
  end

endmodule
